// File: rtl/video_timing_if.sv
// Pixel coordinate / colour bus between the video timing generator and its
// pixel sources, plus the timed video stream handed to the TMDS encoder.
interface video_timing_if;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    logic       pattern_sel;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       frame_start;

    modport master (
        output x, y, r, g, b, hsync, vsync, de, frame_start,
        input  r_in, g_in, b_in, pattern_sel
    );

    modport slave (
        input  x, y, r, g, b, hsync, vsync, de, frame_start,
        output r_in, g_in, b_in, pattern_sel
    );
endinterface

// File: rtl/video_timing.sv
// 640x480@60 timing generator with a PIPE_LAT-deep sync/blank delay line and a
// blank-gated registered pixel output. Define VIDEO_TIMING_PATTERN_EN for colour bars.
module video_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIPE_LAT = 1
) (
    input  logic           pxl_clk,
    input  logic           rst_n,
    video_timing_if.master vid
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SB_C   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE_C   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SB_C   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE_C   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);

    logic [9:0]          r_hcnt;
    logic [9:0]          r_vcnt;
    logic [9:0]          r_x;
    logic [9:0]          r_y;
    logic [9:0]          w_hcnt_nxt;
    logic [9:0]          w_vcnt_nxt;
    logic                w_active_nxt;
    logic                w_active0;
    logic                w_hs0;
    logic                w_vs0;
    logic                w_fs0;
    logic [PIPE_LAT-1:0] r_act_d;
    logic [PIPE_LAT-1:0] r_hs_d;
    logic [PIPE_LAT-1:0] r_vs_d;
    logic [PIPE_LAT-1:0] r_fs_d;
    logic [23:0]         w_src_rgb;
    logic [23:0]         r_rgb;
    logic                r_de;
    logic                r_hsync;
    logic                r_vsync;
    logic                r_fs;

    // Next raster position and stage-0 decodes of the current position.
    always_comb begin
        w_hcnt_nxt = r_hcnt + 10'd1;
        w_vcnt_nxt = r_vcnt;
        if (r_hcnt == H_LAST_C) begin
            w_hcnt_nxt = 10'd0;
            if (r_vcnt == V_LAST_C) begin
                w_vcnt_nxt = 10'd0;
            end else begin
                w_vcnt_nxt = r_vcnt + 10'd1;
            end
        end else begin
            w_hcnt_nxt = r_hcnt + 10'd1;
        end
        w_active_nxt = (w_hcnt_nxt < H_ACT_C) && (w_vcnt_nxt < V_ACT_C);
        w_active0    = (r_hcnt < H_ACT_C) && (r_vcnt < V_ACT_C);
        w_hs0        = (r_hcnt >= H_SB_C) && (r_hcnt < H_SE_C);
        w_vs0        = (r_vcnt >= V_SB_C) && (r_vcnt < V_SE_C);
        w_fs0        = (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
    end

    // Raster counters; x/y are registered from the next position so they track hcnt/vcnt.
    always_ff @(posedge pxl_clk) begin
        if (!rst_n) begin
            r_hcnt <= 10'd0;
            r_vcnt <= 10'd0;
            r_x    <= 10'd0;
            r_y    <= 10'd0;
        end else begin
            r_hcnt <= w_hcnt_nxt;
            r_vcnt <= w_vcnt_nxt;
            r_x    <= w_active_nxt ? w_hcnt_nxt : 10'd0;
            r_y    <= w_active_nxt ? w_vcnt_nxt : 10'd0;
        end
    end

    // Delay line matching the pixel-source latency.
    always_ff @(posedge pxl_clk) begin
        if (!rst_n) begin
            r_act_d <= {PIPE_LAT{1'b0}};
            r_hs_d  <= {PIPE_LAT{1'b0}};
            r_vs_d  <= {PIPE_LAT{1'b0}};
            r_fs_d  <= {PIPE_LAT{1'b0}};
        end else begin
            r_act_d[0] <= w_active0;
            r_hs_d[0]  <= w_hs0;
            r_vs_d[0]  <= w_vs0;
            r_fs_d[0]  <= w_fs0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_act_d[i] <= r_act_d[i-1];
                r_hs_d[i]  <= r_hs_d[i-1];
                r_vs_d[i]  <= r_vs_d[i-1];
                r_fs_d[i]  <= r_fs_d[i-1];
            end
        end
    end

`ifdef VIDEO_TIMING_PATTERN_EN
    logic [23:0] r_bar_d [PIPE_LAT];

    function automatic logic [23:0] bar_colour(input logic [9:0] col);
        logic [23:0] rgb;
        if (col < 10'd80) begin
            rgb = 24'hffffff;
        end else if (col < 10'd160) begin
            rgb = 24'hffff00;
        end else if (col < 10'd240) begin
            rgb = 24'h00ffff;
        end else if (col < 10'd320) begin
            rgb = 24'h00ff00;
        end else if (col < 10'd400) begin
            rgb = 24'hff00ff;
        end else if (col < 10'd480) begin
            rgb = 24'hff0000;
        end else if (col < 10'd560) begin
            rgb = 24'h0000ff;
        end else begin
            rgb = 24'h000000;
        end
        return rgb;
    endfunction

    // Colour bars from stage-0 x, delayed to line up with the source response.
    always_ff @(posedge pxl_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_bar_d[i] <= 24'h000000;
            end
        end else begin
            r_bar_d[0] <= bar_colour(r_x);
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_bar_d[i] <= r_bar_d[i-1];
            end
        end
    end

    // Bars replace the source colour when selected.
    always_comb begin
        if (vid.pattern_sel) begin
            w_src_rgb = r_bar_d[PIPE_LAT-1];
        end else begin
            w_src_rgb = {vid.r_in, vid.g_in, vid.b_in};
        end
    end
`else
    // Without the pattern generator the source colour always passes through.
    always_comb begin
        w_src_rgb = {vid.r_in, vid.g_in, vid.b_in};
    end
`endif

    // Output stage: blank-gated colour and sync at the configured polarity.
    always_ff @(posedge pxl_clk) begin
        if (!rst_n) begin
            r_de    <= 1'b0;
            r_rgb   <= 24'h000000;
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_fs    <= 1'b0;
        end else begin
            r_de    <= r_act_d[PIPE_LAT-1];
            r_rgb   <= r_act_d[PIPE_LAT-1] ? w_src_rgb : 24'h000000;
            r_hsync <= r_hs_d[PIPE_LAT-1] ~^ SYNC_POL;
            r_vsync <= r_vs_d[PIPE_LAT-1] ~^ SYNC_POL;
            r_fs    <= r_fs_d[PIPE_LAT-1];
        end
    end

    assign vid.x           = r_x;
    assign vid.y           = r_y;
    assign vid.r           = r_rgb[23:16];
    assign vid.g           = r_rgb[15:8];
    assign vid.b           = r_rgb[7:0];
    assign vid.de          = r_de;
    assign vid.hsync       = r_hsync;
    assign vid.vsync       = r_vsync;
    assign vid.frame_start = r_fs;
endmodule

// File: tb/tb_video_timing.sv
// Scoreboard bench for video_timing: two instances (PIPE_LAT 1 and 3) on a
// shortened vertical raster, each checked pixel by pixel against a bench model.
module tb_video_timing;
    localparam int H_TOT = 800;
    localparam int V_ACT = 6;
    localparam int V_FP  = 1;
    localparam int V_SYN = 2;
    localparam int V_BP  = 1;
    localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
    // {de, hsync, vsync, frame_start, r, g, b}
    localparam logic [27:0] OUT_RST = {1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       psel = 1'b0;
    logic [7:0] rin_v [2];
    logic [7:0] gin_v [2];
    logic [7:0] bin_v [2];

    always #5 clk = ~clk;

    video_timing_if vif0 ();
    video_timing_if vif1 ();

    assign vif0.r_in = rin_v[0];
    assign vif0.g_in = gin_v[0];
    assign vif0.b_in = bin_v[0];
    assign vif0.pattern_sel = psel;
    assign vif1.r_in = rin_v[1];
    assign vif1.g_in = gin_v[1];
    assign vif1.b_in = bin_v[1];
    assign vif1.pattern_sel = psel;

    video_timing #(.V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP), .PIPE_LAT(1))
        dut0 (.pxl_clk(clk), .rst_n(rst_n), .vid(vif0));
    video_timing #(.V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP), .PIPE_LAT(3))
        dut1 (.pxl_clk(clk), .rst_n(rst_n), .vid(vif1));

    logic [27:0] out_s [2];
    logic [19:0] xy_s [2];
    always_comb begin
        out_s[0] = {vif0.de, vif0.hsync, vif0.vsync, vif0.frame_start, vif0.r, vif0.g, vif0.b};
        out_s[1] = {vif1.de, vif1.hsync, vif1.vsync, vif1.frame_start, vif1.r, vif1.g, vif1.b};
        xy_s[0]  = {vif0.x, vif0.y};
        xy_s[1]  = {vif1.x, vif1.y};
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle-time %0t)", tag, got, exp, $time);
        end
    endtask

    // Model state
    int          mh, mv, mode, cyc;
    logic [27:0] q0 [$];
    logic [27:0] q1 [$];
    logic [19:0] xyh [2][4];
    logic [27:0] prev_o;
    int          t_de, t_hs, t_vs, t_fs, de_lines;
    bit          de_pend, hs_seen, vs_seen, fs_seen;

    function automatic logic [23:0] bar_rgb(input int col);
        case (col / 80)
            0:       return 24'hffffff;
            1:       return 24'hffff00;
            2:       return 24'h00ffff;
            3:       return 24'h00ff00;
            4:       return 24'hff00ff;
            5:       return 24'hff0000;
            6:       return 24'h0000ff;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [27:0] exp_pix(input int h, input int v, input int md);
        logic        act, hs, vs, fs;
        logic [23:0] col;
        act = (h < 640) && (v < V_ACT);
        hs  = (h >= 656) && (h < 752);
        vs  = (v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYN);
        fs  = (h == 0) && (v == 0);
        if (md == 1) col = 24'hffffff;
        else         col = {8'(h), 8'(v), 8'h3c};
`ifdef VIDEO_TIMING_PATTERN_EN
        if (md == 2) col = bar_rgb(h);
`endif
        if (!act) col = 24'h000000;
        return {act, ~hs, ~vs, fs, col};
    endfunction

    function automatic logic [19:0] exp_xy(input int h, input int v);
        if ((h < 640) && (v < V_ACT)) return {10'(h), 10'(v)};
        return 20'h00000;
    endfunction

    task automatic clear_model();
        mh = 0; mv = 0;
        q0.delete(); q1.delete();
        repeat (2) q0.push_back(OUT_RST);
        repeat (4) q1.push_back(OUT_RST);
        for (int k = 0; k < 2; k++) for (int j = 0; j < 4; j++) xyh[k][j] = 20'h00000;
        prev_o = OUT_RST;
        de_pend = 0; hs_seen = 0; vs_seen = 0; fs_seen = 0; de_lines = 0;
    endtask

    task automatic geometry(input logic [27:0] o);
        if (o[24]) begin
            if (fs_seen) begin
                chk("fs_period", cyc - t_fs, H_TOT * V_TOT);
                chk("de_lines", de_lines, V_ACT);
            end
            t_fs = cyc; fs_seen = 1; de_lines = 0;
        end
        if (o[27] && !prev_o[27]) begin t_de = cyc; de_pend = 1; de_lines++; end
        if (!o[27] && prev_o[27]) chk("de_len", cyc - t_de, 640);
        if (!o[26] && prev_o[26]) begin
            if (de_pend) chk("hs_ofs", cyc - t_de, 656);
            de_pend = 0; t_hs = cyc; hs_seen = 1;
        end
        if (o[26] && !prev_o[26] && hs_seen) chk("hs_len", cyc - t_hs, 96);
        if (!o[25] && prev_o[25]) begin t_vs = cyc; vs_seen = 1; end
        if (o[25] && !prev_o[25] && vs_seen) chk("vs_len", cyc - t_vs, 1600);
        prev_o = o;
    endtask

    task automatic run_cycle();
        logic [27:0] e;
        int          lat;
        chk("xy_lat1", xy_s[0], exp_xy(mh, mv));
        chk("xy_lat3", xy_s[1], exp_xy(mh, mv));
        e = exp_pix(mh, mv, mode);
        q0.push_back(e);
        q1.push_back(e);
        chk("pix_lat1", out_s[0], q0.pop_front());
        chk("pix_lat3", out_s[1], q1.pop_front());
        geometry(out_s[0]);
        if (mh == H_TOT - 1) begin
            mh = 0;
            mv = (mv == V_TOT - 1) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
        // Pixel-source model: respond with the coordinate seen PIPE_LAT cycles ago.
        psel = (mode == 2);
        for (int k = 0; k < 2; k++) begin
            lat = (k == 0) ? 1 : 3;
            for (int j = 3; j > 0; j--) xyh[k][j] = xyh[k][j-1];
            xyh[k][0] = xy_s[k];
            if (mode == 1) begin
                rin_v[k] = 8'hff; gin_v[k] = 8'hff; bin_v[k] = 8'hff;
            end else begin
                rin_v[k] = xyh[k][lat][17:10];
                gin_v[k] = xyh[k][lat][7:0];
                bin_v[k] = 8'h3c;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rin_v[k] = 8'hff; gin_v[k] = 8'hff; bin_v[k] = 8'hff;
        end
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            chk("rst_out_lat1", out_s[0], OUT_RST);
            chk("rst_out_lat3", out_s[1], OUT_RST);
            chk("rst_xy_lat1", xy_s[0], 20'h00000);
            chk("rst_xy_lat3", xy_s[1], 20'h00000);
        end
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic run_to(input int h, input int v, input bit use_v);
        for (int i = 0; i < H_TOT * V_TOT; i++) begin
            if (mh == h && (!use_v || mv == v)) break;
            run_cycle();
        end
    endtask

    initial begin
        cyc = 0; mode = 0;
        t_de = 0; t_hs = 0; t_vs = 0; t_fs = 0;
        do_reset(5);
        repeat (2 * H_TOT * V_TOT) run_cycle();
        run_to(700, 0, 1'b0);
        mode = 1;
        repeat (4000) run_cycle();
        run_to(700, 0, 1'b0);
        mode = 2;
        repeat (H_TOT * V_TOT) run_cycle();
        run_to(300, 2, 1'b1);
        do_reset(1);
        mode = 0;
        repeat (H_TOT * V_TOT + 1000) run_cycle();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/video_timing.md
# video_timing

Pixel-clock video timing generator and pixel-output stage for the 640x480@60 display path. Drives the `x`/`y` coordinate bus consumed by pixel-source blocks (the Game of Life renderer and future overlays), and accepts their registered `r`/`g`/`b` response. Emits `hsync`/`vsync`/`de` and final RGB, all pipeline-aligned, to the HDMI/TMDS encoder.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vsync width in lines
- `V_BP`, 33: vertical back porch
- `SYNC_POL`, 0: sync asserted level (0 = active-low)
- `PIPE_LAT`, 1: pixel-source latency in cycles from `x`/`y` to `r_in`/`g_in`/`b_in`; range 1..4

- `pxl_clk`  in  1  pixel clock; the only clock
- `rst_n`  in  1  synchronous, active-low reset
- `x`  out  10  active column, 0 in blanking
- `y`  out  10  active row, 0 in blanking
- `r_in`, `g_in`, `b_in`  in  8 each  pixel-source colour, `PIPE_LAT` cycles after `x`/`y`
- `pattern_sel`  in  1  test-pattern select (see Configuration)
- `r`, `g`, `b`  out  8 each  final colour
- `hsync`, `vsync`  out  1  sync at `SYNC_POL` level when asserted
- `de`  out  1  data enable, high for visible pixels
- `frame_start`  out  1  one-cycle pulse, aligned with output of pixel (0,0)

## Operation
- `hcnt` 0..H_TOTAL-1 (H_TOTAL = sum of H terms = 800); `vcnt` 0..V_TOTAL-1 (525). `hcnt` increments every cycle and wraps to 0. `vcnt` increments only on `hcnt` wrap. At `hcnt` = 799 and `vcnt` = 524, both wrap to 0 on the same edge.
- Stage 0, the counter state: `active0` = `hcnt` < H_ACTIVE && `vcnt` < V_ACTIVE. `x` = `active0` ? `hcnt` : 0, and `y` = `active0` ? `vcnt` : 0. Both are driven from registers and are glitch-free.
- `hs0` is asserted for `hcnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), which is 656..751.
- `vs0` is asserted for `vcnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), which is 490..491, for whole lines.
- `fs0` = (`hcnt` == 0 && `vcnt` == 0).
- `active0`, `hs0`, `vs0` and `fs0` pass through a `PIPE_LAT`-deep shift register.
- Output stage, registered on every edge:
  - `de` <= delayed active.
  - `r`/`g`/`b` <= delayed active ? `*_in` : 0.
  - `hsync`/`vsync` <= delayed sync XNOR `SYNC_POL`, which gives the asserted level when high.
  - `frame_start` <= delayed `fs0`.
- Blanking forces RGB to 0 regardless of `*_in`.

## Timing
- Latency: `x`/`y` to the matching `r`/`g`/`b`/`de`/`hsync`/`vsync`/`frame_start` is PIPE_LAT+1 cycles.
- Reset (`rst_n` low at an edge):
  - `hcnt` = `vcnt` = 0 and `x` = `y` = 0.
  - Delay line cleared.
  - `de` = 0, `r`/`g`/`b` = 0, `frame_start` = 0.
  - `hsync` = `vsync` = deasserted level (1 for `SYNC_POL` = 0).
- Reset applied mid-frame: the same values at the next edge. No partial-line state survives.
- After release: `x`/`y` = (0,0) during the first cycle with `rst_n` high.
  - `hcnt` advances on the following edge.
  - The first `de` = 1 appears PIPE_LAT+1 cycles after release.
  - `frame_start` is asserted in that same cycle.
- Line period is 800 cycles, with `de` high for 640 of them. Frame period is 420000 cycles.
- Sync timing in the output domain:
  - `hsync` falls 656 cycles after `de` rises, at line start.
  - `vsync` spans exactly 1600 cycles.

## Configuration
- `VIDEO_TIMING_PATTERN_EN` defined: a colour-bar generator is compiled in.
  - Eight 80-pixel bars from the stage-0 `x`, in the order white, yellow, cyan, green, magenta, red, blue, black, with components 0xff/0x00.
  - The bars are delayed PIPE_LAT cycles.
  - When `pattern_sel` = 1, the bars replace `*_in` at the output stage. Blanking still forces 0.
- Macro undefined: no pattern logic. `pattern_sel` is present but ignored, and output is always `*_in` (blank-gated).

## Test plan
- Reset: hold `rst_n` low 5 cycles with `*_in` = 0xff -> `r`/`g`/`b` = 0, `de` = 0, `hsync` = `vsync` = 1, `x` = `y` = 0. Release -> first `de` = 1 and `frame_start` = 1 at cycle PIPE_LAT+1.
- Line/frame geometry: run 2 frames -> `de` high 640 cycles per 800; 480 `de` lines per frame; `hsync` low 96 cycles beginning 656 cycles after each `de` rise; `vsync` low 1600 cycles; `frame_start` period 420000.
- Alignment, `PIPE_LAT` = 1 and `PIPE_LAT` = 3: model source drives `r_in` = `x`[7:0] and `g_in` = `y`[7:0], delayed `PIPE_LAT` -> whenever `de` = 1, `r` equals the active column index mod 256 and `g` equals the row mod 256.
- Blanking gate: `*_in` forced to 0xff -> `r`/`g`/`b` = 0 whenever `de` = 0, and 0xff whenever `de` = 1.
- Mid-frame reset: assert `rst_n` low for 1 cycle at `vcnt` = 200, `hcnt` = 300 -> next-cycle outputs equal the reset values; the next `frame_start` comes PIPE_LAT+1 cycles after release.
- `VIDEO_TIMING_PATTERN_EN` with `pattern_sel` = 1 -> at the `de` columns listed below, RGB is as shown; with the macro undefined, `pattern_sel` = 1 has no effect.
  - Column 0 -> ff/ff/ff
  - Column 80 -> ff/ff/00
  - Column 639 -> 00/00/00
